fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: credit-limited request issue, in-order response buffer, redirect flush.
// Optional same-cycle response bypass is enabled by defining FETCH_UNIT_BYPASS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] bf_cnt_q, bf_cnt_d;
  logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [AW-1:0] bf_wr_q, bf_wr_d, bf_rd_q, bf_rd_d;
  logic          started_q;

  logic [31:0] pq_mem    [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic [31:0] buf_instr [DEPTH];

  logic          req_fire, rsp_keep, bypass, buf_nonempty;
  logic          buf_push, buf_pop, pq_push, pq_pop;
  logic [CW:0]   in_use;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^redirect_pc[1:0];

  // Dropped (stale) responses still hold credit until they arrive.
  assign in_use         = {1'b0, outst_q} + {1'b0, bf_cnt_q};
  assign imem_req_valid = started_q && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep     = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign buf_nonempty = (bf_cnt_q != '0);
`ifdef FETCH_UNIT_BYPASS_EN
  assign bypass = rsp_keep && !buf_nonempty;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = (buf_nonempty || bypass) && !redirect_valid;
  assign buf_pop   = out_valid && out_ready && buf_nonempty;
  assign buf_push  = rsp_keep && !(bypass && out_ready);
  assign pq_push   = req_fire;
  assign pq_pop    = rsp_keep;

  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    if (out_valid) begin
      if (buf_nonempty) begin
        out_pc    = buf_pc[bf_rd_q];
        out_instr = buf_instr[bf_rd_q];
      end else begin
        out_pc    = pq_mem[pq_rd_q];
        out_instr = imem_rsp_data;
      end
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    bf_cnt_d   = bf_cnt_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;
    bf_wr_d    = bf_wr_q;
    bf_rd_d    = bf_rd_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      outst_d    = outst_q - CW'(imem_rsp_valid);
      drop_d     = outst_q - CW'(imem_rsp_valid);
      bf_cnt_d   = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
      bf_wr_d    = '0;
      bf_rd_d    = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (pq_push) pq_wr_d = pq_wr_q + AW'(1);
      if (pq_pop)  pq_rd_d = pq_rd_q + AW'(1);
      if (buf_push) bf_wr_d = bf_wr_q + AW'(1);
      if (buf_pop)  bf_rd_d = bf_rd_q + AW'(1);
      bf_cnt_d = bf_cnt_q + CW'(buf_push) - CW'(buf_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      outst_q    <= '0;
      drop_q     <= '0;
      bf_cnt_q   <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      bf_wr_q    <= '0;
      bf_rd_q    <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      bf_cnt_q   <= bf_cnt_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      bf_wr_q    <= bf_wr_d;
      bf_rd_q    <= bf_rd_d;
      started_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pq_push) pq_mem[pq_wr_q] <= fetch_pc_q;
    if (buf_push) begin
      buf_pc[bf_wr_q]    <= pq_mem[pq_rd_q];
      buf_instr[bf_wr_q] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a behavioural memory and PC model feed a scoreboard queue
// that an independent output monitor drains and compares.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0040;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_UNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, reset, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, out_valid, out_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, out_pc, out_instr;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          stale;
  } mem_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  mem_t        mem_q[$];   // requests accepted by the memory, not yet answered
  exp_t        exp_q[$];   // instructions decode is still owed, in order
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, last_due = 0;
  logic [31:0] model_pc;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    mem_q.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd0);
    last_due = cyc;
  endtask

  initial begin
    bit          redir, del, fresh, mid_done, drain;
    logic [31:0] rp;
    int          lat, due;
    redirect_pc = '0;
    imem_rsp_data = '0;
    mid_done = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cyc++;
      if (!mid_done && c > 1500 && mem_q.size() >= 2) begin
        mid_done = 1'b1;
        do_reset();
        continue;
      end
      drain = (c >= 2900);
      redir = !drain && ($urandom_range(0, 24) == 0);
      rp = $urandom;
      if ($urandom_range(0, 2) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'h0000_000F);
      redirect_valid = redir;
      redirect_pc = rp;
      del = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rsp_valid = del;
      imem_rsp_data = del ? mem_q[0].data : $urandom;
      fresh = del && !mem_q[0].stale && !redir;
      imem_req_ready = !drain && ($urandom_range(0, 3) != 0);
      if (drain || (c % 400) < 100) out_ready = 1'b1;
      else if ((c % 400) < 250)     out_ready = ($urandom_range(0, 1) == 1);
      else                          out_ready = ($urandom_range(0, 9) == 0);
      #1;
      chk("req_valid", 32'(imem_req_valid),
          32'(!redir && (mem_q.size() + exp_q.size() < DEPTH)));
      chk("out_valid", 32'(out_valid), 32'(!redir && (exp_q.size() > 0 || (BYP && fresh))));
      if (del) begin
        if (fresh) exp_q.push_back('{pc: mem_q[0].pc, data: mem_q[0].data});
        void'(mem_q.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        lat = $urandom_range(1, 4);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        mem_q.push_back('{pc: model_pc, data: $urandom, due: due, stale: 1'b0});
        model_pc = model_pc + 32'd4;
      end
      if (redir) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        model_pc = {rp[31:2], 2'b00};
      end
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    chk("drain_expected_left", 32'(exp_q.size()), 32'd0);
    chk("drain_memory_left", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Output monitor: every handshake pops the scoreboard; idle cycles must show the NOP.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got pc %h instr %h expected no instruction (cycle %0d)",
                   out_pc, out_instr, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.data);
        end
      end else if (!out_valid) begin
        chk("idle_out_pc", out_pc, 32'd0);
        chk("idle_out_instr", out_instr, NOP);
      end
    end
  end
endmodule
